// File: rtl/subword_store_unit.sv
// rtl/subword_store_unit.sv - RMW sequencer for SB/SH stores; optional trap via SUBWORD_MISALIGN_TRAP_EN
module subword_store_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_req,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    output logic        mem_write_bh,
    output logic        st_done,
    output logic        st_misaligned
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  lane_q;
    logic        half_q;
    logic [15:0] data_q;
    logic [31:0] merged;
    logic        start;
    logic        mis_req;
    logic        unused_wdata_hi;

    // Only the low half of the store data can ever reach memory.
    assign unused_wdata_hi = ^st_wdata[31:16];

`ifdef SUBWORD_MISALIGN_TRAP_EN
    // Odd-address half stores are refused and reported instead of started.
    assign mis_req = st_req && (st_size == 2'b01) && st_addr[0] && (state == S_IDLE);
`else
    assign mis_req = 1'b0;
`endif

    assign start = st_req && !st_size[1] && (state == S_IDLE) && !mis_req;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; WAIT exits once the read data is due on mem_rdata.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RD;
            S_RD:    state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 2'd1) state_nxt = S_WR;
            S_WR:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane merge of the latched store data into the word read from memory.
    always_comb begin
        merged = mem_rdata;
        if (half_q) begin
            if (lane_q[1]) merged[31:16] = data_q;
            else           merged[15:0]  = data_q;
        end else begin
            case (lane_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end
    end

    // Request latch, read-latency countdown and merged-word capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 2'd0;
            lane_q    <= 2'd0;
            half_q    <= 1'b0;
            data_q    <= 16'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            if (start) begin
                mem_addr <= {st_addr[31:2], 2'b00};
                lane_q   <= st_addr[1:0];
                half_q   <= st_size[0];
                data_q   <= st_wdata[15:0];
                cnt      <= 2'(RD_LAT);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 2'd1;
                if (cnt == 2'd1) begin
                    mem_wdata <= merged;
                end
            end
        end
    end

`ifdef SUBWORD_MISALIGN_TRAP_EN
    // One-cycle trap pulse; a held request toggles it so each pulse is distinct.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_misaligned <= 1'b0;
        end else begin
            st_misaligned <= mis_req && !st_misaligned;
        end
    end
`else
    assign st_misaligned = 1'b0;
`endif

    assign mem_re       = (state == S_RD);
    assign mem_we       = (state == S_WR);
    assign st_done      = (state == S_DONE);
    assign mem_write_bh = start || (state == S_RD) || (state == S_WAIT) || (state == S_WR);

endmodule

// File: tb/tb_subword_store_unit.sv
// tb/tb_subword_store_unit.sv - self-checking bench for subword_store_unit at RD_LAT 1 and 3
module tb_subword_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_req    [2];
    logic [1:0]  st_size   [2];
    logic [31:0] st_addr   [2];
    logic [31:0] st_wdata  [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_re    [2];
    logic        mem_we    [2];
    logic        mem_write_bh [2];
    logic        st_done   [2];
    logic        st_misaligned [2];

    logic [31:0] mem [2][256];
    logic [31:0] rp  [2][3];
    logic        pre_en;
    logic        pre_d;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    subword_store_unit #(.RD_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .st_req(st_req[0]), .st_size(st_size[0]), .st_addr(st_addr[0]), .st_wdata(st_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_re(mem_re[0]), .mem_we(mem_we[0]), .mem_write_bh(mem_write_bh[0]),
        .st_done(st_done[0]), .st_misaligned(st_misaligned[0])
    );

    subword_store_unit #(.RD_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .st_req(st_req[1]), .st_size(st_size[1]), .st_addr(st_addr[1]), .st_wdata(st_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_re(mem_re[1]), .mem_we(mem_we[1]), .mem_write_bh(mem_write_bh[1]),
        .st_done(st_done[1]), .st_misaligned(st_misaligned[1])
    );

    // Word memories; read data shows up RD_LAT cycles after mem_re, garbage otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d]) mem[d][mem_addr[d][9:2]] <= mem_wdata[d];
            rp[d][0] <= mem_re[d] ? mem[d][mem_addr[d][9:2]] : $urandom;
            rp[d][1] <= rp[d][0];
            rp[d][2] <= rp[d][1];
        end
        if (pre_en) mem[pre_d][pre_idx] <= pre_val;
    end
    assign mem_rdata[0] = rp[0][0];
    assign mem_rdata[1] = rp[1][2];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
        int          sh;
        logic [31:0] m;
        if (sz == 2'b00) begin
            sh = 8 * int'(a % 4);
            m  = 32'hFF << sh;
        end else begin
            sh = 16 * int'((a % 4) / 2);
            m  = 32'hFFFF << sh;
        end
        return (old & ~m) | ((wd << sh) & m);
    endfunction

    task automatic preload(input int d, input logic [7:0] idx, input logic [31:0] v);
        pre_en = 1'b1; pre_d = d[0]; pre_idx = idx; pre_val = v;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Drives one SB/SH and checks every cycle against the expected schedule.
    task automatic run_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] exp);
        int L;
        L = (d == 0) ? 1 : 3;
        st_req[d] = 1'b1; st_size[d] = sz; st_addr[d] = a; st_wdata[d] = wd;
        for (int k = 0; k <= 3 + L; k++) begin
            @(negedge clk);
            chk_bit($sformatf("d%0d bh c%0d", d, k), mem_write_bh[d], k <= 2 + L);
            chk_bit($sformatf("d%0d re c%0d", d, k), mem_re[d], k == 1);
            chk_bit($sformatf("d%0d we c%0d", d, k), mem_we[d], k == 2 + L);
            chk_bit($sformatf("d%0d done c%0d", d, k), st_done[d], k == 3 + L);
            chk_bit($sformatf("d%0d mis c%0d", d, k), st_misaligned[d], 1'b0);
            if (k == 2 + L) begin
                chk_word($sformatf("d%0d addr", d), mem_addr[d], {a[31:2], 2'b00});
                chk_word($sformatf("d%0d wdata", d), mem_wdata[d], exp);
            end
            @(posedge clk); #1;
        end
        st_req[d] = 1'b0; st_size[d] = 2'($urandom); st_addr[d] = $urandom; st_wdata[d] = $urandom;
        chk_word($sformatf("d%0d mem[%h]", d, a[9:2]), mem[d][a[9:2]], exp);
    endtask

    task automatic check_idle(input int d, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk_bit($sformatf("%s bh", tag), mem_write_bh[d], 1'b0);
            chk_bit($sformatf("%s re", tag), mem_re[d], 1'b0);
            chk_bit($sformatf("%s we", tag), mem_we[d], 1'b0);
            chk_bit($sformatf("%s done", tag), st_done[d], 1'b0);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        int          d;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0, 2'b00, 32'h0000_0103, 32'h0000_00AA, 32'h1122_3344, 32'hAA22_3344};
        vecs[1] = '{1, 2'b01, 32'h0000_0202, 32'h0000_BEEF, 32'hDEAD_0000, 32'hBEEF_0000};
        vecs[2] = '{0, 2'b00, 32'h8000_0000, 32'h0000_005A, 32'hFFFF_FFFF, 32'hFFFF_FF5A};
        vecs[3] = '{1, 2'b00, 32'h0000_0011, 32'hFFFF_FFC3, 32'h0123_4567, 32'h0123_C367};
        vecs[4] = '{0, 2'b01, 32'h0000_0040, 32'hFFFF_1234, 32'hAAAA_AAAA, 32'hAAAA_1234};
        vecs[5] = '{1, 2'b00, 32'h0000_0082, 32'hFFFF_FF77, 32'h0000_0000, 32'h0077_0000};

        pre_en = 1'b0; pre_d = 1'b0; pre_idx = 8'd0; pre_val = 32'd0;
        for (int d = 0; d < 2; d++) begin
            st_req[d] = 1'b0; st_size[d] = 2'b00; st_addr[d] = 32'd0; st_wdata[d] = 32'd0;
        end
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk_word($sformatf("rst d%0d addr", d), mem_addr[d], 32'd0);
            chk_word($sformatf("rst d%0d wdata", d), mem_wdata[d], 32'd0);
            chk_bit($sformatf("rst d%0d re", d), mem_re[d], 1'b0);
            chk_bit($sformatf("rst d%0d we", d), mem_we[d], 1'b0);
            chk_bit($sformatf("rst d%0d bh", d), mem_write_bh[d], 1'b0);
            chk_bit($sformatf("rst d%0d done", d), st_done[d], 1'b0);
            chk_bit($sformatf("rst d%0d mis", d), st_misaligned[d], 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            preload(vecs[i].d, vecs[i].addr[9:2], vecs[i].init);
            run_store(vecs[i].d, vecs[i].sz, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end

        // Word and reserved sizes must not touch memory or stall.
        for (int d = 0; d < 2; d++) begin
            st_req[d] = 1'b1; st_size[d] = 2'b10; st_addr[d] = 32'h100; st_wdata[d] = 32'h1;
            check_idle(d, 4, $sformatf("sw d%0d", d));
            st_size[d] = 2'b11;
            check_idle(d, 3, $sformatf("sz3 d%0d", d));
            st_req[d] = 1'b0;
        end

        // Asynchronous reset in WAIT kills the pending write.
        preload(1, 8'hFC, 32'h1357_9BDF);
        st_req[1] = 1'b1; st_size[1] = 2'b01; st_addr[1] = 32'h3F0; st_wdata[1] = 32'h4444;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0; st_req[1] = 1'b0;
        #1;
        chk_word("arst addr", mem_addr[1], 32'd0);
        chk_word("arst wdata", mem_wdata[1], 32'd0);
        chk_bit("arst re", mem_re[1], 1'b0);
        chk_bit("arst we", mem_we[1], 1'b0);
        chk_bit("arst bh", mem_write_bh[1], 1'b0);
        chk_bit("arst done", st_done[1], 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_idle(1, 8, "post arst");
        chk_word("arst mem kept", mem[1][8'hFC], 32'h1357_9BDF);

        // Back-to-back byte stores with minimum spacing.
        preload(0, 8'h40, 32'h0);
        run_store(0, 2'b00, 32'h100, 32'h01, 32'h0000_0001);
        run_store(0, 2'b00, 32'h101, 32'h02, 32'h0000_0201);
        check_idle(0, 2, "b2b tail");

`ifdef SUBWORD_MISALIGN_TRAP_EN
        // Held odd half store: trap pulses every other cycle, no memory access.
        st_req[0] = 1'b1; st_size[0] = 2'b01; st_addr[0] = 32'h301; st_wdata[0] = 32'hCAFE;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_bit($sformatf("trap mis c%0d", k), st_misaligned[0], (k % 2) == 1);
            chk_bit($sformatf("trap bh c%0d", k), mem_write_bh[0], 1'b0);
            chk_bit($sformatf("trap re c%0d", k), mem_re[0], 1'b0);
            chk_bit($sformatf("trap we c%0d", k), mem_we[0], 1'b0);
            @(posedge clk); #1;
        end
        st_req[0] = 1'b0;
        check_idle(0, 2, "trap tail");
`else
        preload(0, 8'hC0, 32'h5566_7788);
        run_store(0, 2'b01, 32'h301, 32'hCAFE, 32'h5566_CAFE);
`endif

        // Randomised stores checked against the reference merge.
        for (int i = 0; i < 60; i++) begin
            int          d;
            logic [1:0]  sz;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] init;
            d    = int'($urandom % 2);
            sz   = 2'($urandom % 2);
            a    = $urandom;
            wd   = $urandom;
            init = $urandom;
`ifdef SUBWORD_MISALIGN_TRAP_EN
            if (sz == 2'b01) a[0] = 1'b0;
`endif
            preload(d, a[9:2], init);
            run_store(d, sz, a, wd, ref_merge(init, sz, a, wd));
            if ($urandom % 3 == 0) check_idle(d, 1, "rand gap");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
